// File: rtl/multicycle_controller.sv
// Multicycle control unit for the 8-bit accumulator datapath: sequences fetch,
// decode, memory access, execute and branch steps and drives datapath strobes.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       pc_write,
  output logic       acc_write,
  output logic       pc_src,
  output logic       acc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_func,
  output logic       busy,
  output logic       instr_done
);

  localparam int unsigned OPC_W  = 3;
  localparam int unsigned FUNC_W = 2;

  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_AND = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_NOT = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_STA = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(7);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM_RD = 3'd3,
    S_EXEC   = 3'd4,
    S_STORE  = 3'd5,
    S_BRANCH = 3'd6
  } state_t;

  state_t state_q, state_d;

  // State register; reset drops to IDLE immediately so all outputs clear at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and output decode; memory-dependent strobes are Mealy on mem_ready.
  always_comb begin
    state_d    = state_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    mdr_write  = 1'b0;
    pc_write   = 1'b0;
    acc_write  = 1'b0;
    pc_src     = 1'b0;
    acc_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_func   = FUNC_W'(0);
    instr_done = 1'b0;
    busy       = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          // Load IR and advance PC via ALU (PC + 1) in the same edge.
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_LDA: state_d = S_MEM_RD;
          OP_NOT:                         state_d = S_EXEC;
          OP_STA:                         state_d = S_STORE;
          default:                        state_d = S_BRANCH;
        endcase
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          mdr_write = 1'b1;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        acc_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
        if (opcode == OP_LDA) begin
          acc_src = 1'b1;
        end else begin
          alu_src_a = 1'b1;
          alu_func  = opcode[FUNC_W-1:0];
        end
      end
      S_STORE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_BRANCH: begin
        pc_src     = 1'b1;
        instr_done = 1'b1;
        pc_write   = (opcode == OP_JMP) || ((opcode == OP_JZ) && zero);
        state_d    = S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction cycle traces built from the
// opcode timing rules, played with random waits, start and zero noise.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_read, mem_write, iord, ir_write, mdr_write, pc_write, acc_write;
  logic       pc_src, acc_src, alu_src_a, busy, instr_done;
  logic [1:0] alu_src_b, alu_func;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .ir_write(ir_write), .mdr_write(mdr_write), .pc_write(pc_write),
    .acc_write(acc_write), .pc_src(pc_src), .acc_src(acc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_func(alu_func),
    .busy(busy), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  logic [15:0] act;
  assign act = {mem_read, mem_write, iord, ir_write, mdr_write, pc_write, acc_write,
                pc_src, acc_src, alu_src_a, alu_src_b, alu_func, busy, instr_done};

  localparam logic [15:0] MRD   = 16'h8000;
  localparam logic [15:0] MWR   = 16'h4000;
  localparam logic [15:0] IORD  = 16'h2000;
  localparam logic [15:0] IRW   = 16'h1000;
  localparam logic [15:0] MDRW  = 16'h0800;
  localparam logic [15:0] PCW   = 16'h0400;
  localparam logic [15:0] ACCW  = 16'h0200;
  localparam logic [15:0] PCSRC = 16'h0100;
  localparam logic [15:0] ACCS  = 16'h0080;
  localparam logic [15:0] SRCA  = 16'h0040;
  localparam logic [15:0] SRCB1 = 16'h0010;
  localparam logic [15:0] BUSY  = 16'h0002;
  localparam logic [15:0] DONE  = 16'h0001;

  typedef struct packed {
    logic [2:0]  op;
    logic        mr;
    logic        z;
    logic [15:0] exp;
  } cyc_t;

  cyc_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic void push(input logic [2:0] op, input logic mr, input logic z,
                               input logic [15:0] e);
    cyc_t c;
    c.op = op; c.mr = mr; c.z = z; c.exp = e;
    q.push_back(c);
  endfunction

  // Expected per-cycle trace of one instruction: fetch waits wf, memory waits wm,
  // zmode 0/1 forces zero in the branch cycle, 2 randomises it.
  function automatic void build(input logic [2:0] op, input int wf, input int wm,
                                input int zmode);
    logic z;
    logic [15:0] ex;
    for (int i = 0; i < wf; i++) push(op, 1'b0, rb(), MRD | BUSY);
    push(op, 1'b1, rb(), MRD | IRW | PCW | SRCB1 | BUSY);
    push(op, rb(), rb(), BUSY);
    if (op == 3'd4) ex = ACCW | DONE | BUSY | ACCS;
    else            ex = ACCW | DONE | BUSY | SRCA | (16'(op[1:0]) << 2);
    case (op)
      3'd0, 3'd1, 3'd2, 3'd4: begin
        for (int i = 0; i < wm; i++) push(op, 1'b0, rb(), MRD | IORD | BUSY);
        push(op, 1'b1, rb(), MRD | IORD | MDRW | BUSY);
        push(op, rb(), rb(), ex);
      end
      3'd3: push(op, rb(), rb(), ex);
      3'd5: begin
        for (int i = 0; i < wm; i++) push(op, 1'b0, rb(), MWR | IORD | BUSY);
        push(op, 1'b1, rb(), MWR | IORD | DONE | BUSY);
      end
      default: begin
        z = (zmode == 2) ? rb() : (zmode == 1);
        push(op, rb(), z, PCSRC | DONE | BUSY | (((op == 3'd6) || z) ? PCW : 16'h0));
      end
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 3'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ready = rb(); zero = rb(); opcode = 3'($urandom); #1;
      n_cmp++;
      if (act !== 16'h0) begin n_err++; $display("FAIL reset_held: got %h want 0000", act); end
    end
    @(negedge clk); rst_n = 1'b1; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ready = rb(); #1;
      n_cmp++;
      if (act !== 16'h0) begin n_err++; $display("FAIL idle_no_start: got %h want 0000", act); end
    end
    @(negedge clk); start = 1'b1; mem_ready = 1'b0; #1;
    n_cmp++;
    if (act !== 16'h0) begin n_err++; $display("FAIL idle_start_cycle: got %h want 0000", act); end
  endtask

  task automatic test_alu_ops();
    cyc_t c;
    build(3'd0, 0, 0, 2); build(3'd1, 0, 0, 2); build(3'd2, 0, 0, 2); build(3'd3, 0, 0, 2);
    for (int k = 0; q.size() > 0; k++) begin
      c = q.pop_front();
      @(negedge clk); start = rb(); mem_ready = c.mr; zero = c.z; opcode = c.op; #1;
      n_cmp++;
      if (act !== c.exp) begin n_err++; $display("FAIL alu_ops cyc%0d op%0d: got %h want %h", k, c.op, act, c.exp); end
    end
  endtask

  task automatic test_lda_sta_waits();
    cyc_t c;
    build(3'd4, 1, 2, 2); build(3'd5, 0, 0, 2); build(3'd5, 2, 3, 2);
    for (int k = 0; q.size() > 0; k++) begin
      c = q.pop_front();
      @(negedge clk); start = rb(); mem_ready = c.mr; zero = c.z; opcode = c.op; #1;
      n_cmp++;
      if (act !== c.exp) begin n_err++; $display("FAIL mem_waits cyc%0d op%0d: got %h want %h", k, c.op, act, c.exp); end
    end
  endtask

  task automatic test_branch();
    cyc_t c;
    build(3'd7, 0, 0, 1); build(3'd7, 0, 0, 0); build(3'd6, 0, 0, 0); build(3'd6, 1, 0, 1);
    for (int k = 0; q.size() > 0; k++) begin
      c = q.pop_front();
      @(negedge clk); start = rb(); mem_ready = c.mr; zero = c.z; opcode = c.op; #1;
      n_cmp++;
      if (act !== c.exp) begin n_err++; $display("FAIL branch cyc%0d op%0d: got %h want %h", k, c.op, act, c.exp); end
    end
  endtask

  task automatic test_random();
    cyc_t c;
    for (int i = 0; i < 60; i++)
      build(3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 2);
    for (int k = 0; q.size() > 0; k++) begin
      c = q.pop_front();
      @(negedge clk); start = rb(); mem_ready = c.mr; zero = c.z; opcode = c.op; #1;
      n_cmp++;
      if (act !== c.exp) begin n_err++; $display("FAIL random cyc%0d op%0d: got %h want %h", k, c.op, act, c.exp); end
    end
  endtask

  task automatic test_reset_mid();
    cyc_t c;
    @(negedge clk); start = 1'b0; mem_ready = 1'b0; #1;
    n_cmp++;
    if (act !== (MRD | BUSY)) begin n_err++; $display("FAIL fetch_wait_pre: got %h want %h", act, MRD | BUSY); end
    #1 rst_n = 1'b0; #1;
    n_cmp++;
    if (act !== 16'h0) begin n_err++; $display("FAIL async_reset_drop: got %h want 0000", act); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); start = rb(); mem_ready = rb(); #1;
      n_cmp++;
      if (act !== 16'h0) begin n_err++; $display("FAIL reset_mid_held: got %h want 0000", act); end
    end
    @(negedge clk); rst_n = 1'b1; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); start = 1'b0; mem_ready = rb(); zero = rb(); #1;
      n_cmp++;
      if (act !== 16'h0) begin n_err++; $display("FAIL post_reset_idle: got %h want 0000", act); end
    end
    @(negedge clk); start = 1'b1; #1;
    build(3'd4, 1, 1, 2); build(3'd7, 0, 0, 1);
    for (int k = 0; q.size() > 0; k++) begin
      c = q.pop_front();
      @(negedge clk); start = rb(); mem_ready = c.mr; zero = c.z; opcode = c.op; #1;
      n_cmp++;
      if (act !== c.exp) begin n_err++; $display("FAIL restart cyc%0d op%0d: got %h want %h", k, c.op, act, c.exp); end
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_lda_sta_waits();
    test_branch();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
